// File: rtl/axi4_bch_drop_arb.sv
// B-channel arbiter: merges master write responses with locally generated
// error responses for dropped writes. Dropped-write IDs are queued in a small FIFO.
module axi4_bch_drop_arb #(
   parameter int         C_AXI_ID_WIDTH   = 10,
   parameter int         C_AXI_USER_WIDTH = 4,
   parameter int         C_DROP_DEPTH     = 4,
   parameter logic [1:0] C_DROP_RESP      = 2'b10
) (
   input  logic                                axi4_aclk,
   input  logic                                axi4_arst,
   input  logic [C_AXI_ID_WIDTH-1:0]           trans_id,
   input  logic                                trans_drop,
   output logic                                trans_drop_ready,
   input  logic                                s_axi4_wvalid,
   input  logic                                s_axi4_wready,
   input  logic                                s_axi4_wlast,
   input  logic                                w_drop,
   output logic [C_AXI_ID_WIDTH-1:0]           s_axi4_bid,
   output logic [1:0]                          s_axi4_bresp,
   output logic [C_AXI_USER_WIDTH-1:0]         s_axi4_buser,
   output logic                                s_axi4_bvalid,
   input  logic                                s_axi4_bready,
   input  logic [C_AXI_ID_WIDTH-1:0]           m_axi4_bid,
   input  logic [1:0]                          m_axi4_bresp,
   input  logic [C_AXI_USER_WIDTH-1:0]         m_axi4_buser,
   input  logic                                m_axi4_bvalid,
   output logic                                m_axi4_bready,
   output logic [$clog2(C_DROP_DEPTH):0]       drop_pending,
   output logic                                proto_err
);

   localparam int AW = $clog2(C_DROP_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_MST, S_DRP} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [C_AXI_ID_WIDTH-1:0] r_fifo [C_DROP_DEPTH];
   logic [AW-1:0]             r_wptr;
   logic [AW-1:0]             r_rptr;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             r_wl_cnt;
   logic                      r_pref_drop;
   logic                      r_proto_err;

   logic                      w_full;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_mst_done;
   logic                      w_elig;
   logic                      w_sel_drp;
   logic                      w_sel_mst;
   logic                      w_wl_inc_req;
   logic                      w_wl_ovf;
   logic [CW-1:0]             w_cnt_nxt;
   logic [CW:0]               w_wl_sum;
   logic [CW-1:0]             w_wl_nxt;

   // A push into a full FIFO still lands when the head pops in the same cycle.
   assign w_full           = (r_cnt == CW'(C_DROP_DEPTH));
   assign w_push           = trans_drop && (!w_full || w_pop);
   assign trans_drop_ready = !w_full;
   assign drop_pending     = r_cnt;
   assign proto_err        = r_proto_err;
   assign w_elig           = (r_cnt != '0) && (r_wl_cnt != '0);
   assign w_pop            = w_sel_drp && s_axi4_bready;
   assign w_mst_done       = w_sel_mst && s_axi4_bready;
   assign w_cnt_nxt        = r_cnt + CW'(w_push) - CW'(w_pop);

   // A completed dropped burst may never outnumber the IDs queued for it.
   assign w_wl_inc_req = s_axi4_wvalid && s_axi4_wready && s_axi4_wlast && w_drop;
   assign w_wl_sum     = {1'b0, r_wl_cnt} + (CW+1)'(w_wl_inc_req) - (CW+1)'(w_pop);
   assign w_wl_ovf     = w_wl_inc_req && (w_wl_sum > {1'b0, w_cnt_nxt});
   assign w_wl_nxt     = w_wl_ovf ? (r_wl_cnt - CW'(w_pop)) : w_wl_sum[CW-1:0];

   always_ff @(posedge axi4_aclk) begin
      if (w_push) r_fifo[r_wptr] <= trans_id;
   end

   always_ff @(posedge axi4_aclk) begin
      if (axi4_arst) begin
         r_state     <= S_IDLE;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_wl_cnt    <= '0;
         r_pref_drop <= 1'b1;
         r_proto_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wl_cnt <= w_wl_nxt;
         if (w_push)   r_wptr <= r_wptr + AW'(1);
         if (w_pop)    r_rptr <= r_rptr + AW'(1);
         if (w_wl_ovf) r_proto_err <= 1'b1;
         if (w_pop)           r_pref_drop <= 1'b0;
         else if (w_mst_done) r_pref_drop <= 1'b1;
      end
   end

   // Grant is combinational in IDLE; a stalled beat locks its source until accepted.
   always_comb begin
      w_state_nxt   = r_state;
      w_sel_drp     = 1'b0;
      w_sel_mst     = 1'b0;
      s_axi4_bid    = m_axi4_bid;
      s_axi4_bresp  = m_axi4_bresp;
      s_axi4_buser  = m_axi4_buser;
      s_axi4_bvalid = 1'b0;
      m_axi4_bready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_elig && (!m_axi4_bvalid || r_pref_drop)) w_sel_drp = 1'b1;
            else if (m_axi4_bvalid)                        w_sel_mst = 1'b1;
            if (w_sel_drp && !s_axi4_bready)      w_state_nxt = S_DRP;
            else if (w_sel_mst && !s_axi4_bready) w_state_nxt = S_MST;
         end
         S_MST: begin
            w_sel_mst = 1'b1;
            if (s_axi4_bready) w_state_nxt = S_IDLE;
         end
         S_DRP: begin
            w_sel_drp = 1'b1;
            if (s_axi4_bready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_sel_drp) begin
         s_axi4_bid    = r_fifo[r_rptr];
         s_axi4_bresp  = C_DROP_RESP;
         s_axi4_buser  = '0;
         s_axi4_bvalid = 1'b1;
      end else if (w_sel_mst) begin
         s_axi4_bvalid = 1'b1;
         m_axi4_bready = s_axi4_bready;
      end
   end

endmodule

// File: tb/tb_axi4_bch_drop_arb.sv
// Directed bench for axi4_bch_drop_arb: drop responses, arbitration
// fairness, beat locking, FIFO full handling, protocol error and reset.
module tb_axi4_bch_drop_arb;

   logic        axi4_aclk = 1'b0;
   logic        axi4_arst;
   logic [9:0]  trans_id;
   logic        trans_drop;
   logic        trans_drop_ready;
   logic        s_axi4_wvalid, s_axi4_wready, s_axi4_wlast, w_drop;
   logic [9:0]  s_axi4_bid;
   logic [1:0]  s_axi4_bresp;
   logic [3:0]  s_axi4_buser;
   logic        s_axi4_bvalid;
   logic        s_axi4_bready;
   logic [9:0]  m_axi4_bid;
   logic [1:0]  m_axi4_bresp;
   logic [3:0]  m_axi4_buser;
   logic        m_axi4_bvalid;
   logic        m_axi4_bready;
   logic [2:0]  drop_pending;
   logic        proto_err;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] exp_ids [4];

   axi4_bch_drop_arb dut (
      .axi4_aclk        (axi4_aclk),
      .axi4_arst        (axi4_arst),
      .trans_id         (trans_id),
      .trans_drop       (trans_drop),
      .trans_drop_ready (trans_drop_ready),
      .s_axi4_wvalid    (s_axi4_wvalid),
      .s_axi4_wready    (s_axi4_wready),
      .s_axi4_wlast     (s_axi4_wlast),
      .w_drop           (w_drop),
      .s_axi4_bid       (s_axi4_bid),
      .s_axi4_bresp     (s_axi4_bresp),
      .s_axi4_buser     (s_axi4_buser),
      .s_axi4_bvalid    (s_axi4_bvalid),
      .s_axi4_bready    (s_axi4_bready),
      .m_axi4_bid       (m_axi4_bid),
      .m_axi4_bresp     (m_axi4_bresp),
      .m_axi4_buser     (m_axi4_buser),
      .m_axi4_bvalid    (m_axi4_bvalid),
      .m_axi4_bready    (m_axi4_bready),
      .drop_pending     (drop_pending),
      .proto_err        (proto_err)
   );

   always #5 axi4_aclk = ~axi4_aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge axi4_aclk);
      #1;
   endtask

   task automatic wbeat(input logic v);
      s_axi4_wvalid = v;
      s_axi4_wready = v;
      s_axi4_wlast  = v;
      w_drop        = v;
   endtask

   task automatic clear_inputs();
      trans_id      = '0;
      trans_drop    = 1'b0;
      wbeat(1'b0);
      s_axi4_bready = 1'b0;
      m_axi4_bid    = '0;
      m_axi4_bresp  = '0;
      m_axi4_buser  = '0;
      m_axi4_bvalid = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      axi4_arst = 1'b1;
      tick();
      axi4_arst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      axi4_arst = 1'b1;
      tick();
      tick();
      #2;
      chk("rst_pending", 32'(drop_pending), 0);
      chk("rst_tdr", 32'(trans_drop_ready), 1);
      chk("rst_perr", 32'(proto_err), 0);
      chk("rst_bvalid", 32'(s_axi4_bvalid), 0);
      m_axi4_bvalid = 1'b1;
      m_axi4_bid    = 10'h007;
      #2;
      chk("rst_bvalid_pass", 32'(s_axi4_bvalid), 1);
      chk("rst_bid_pass", 32'(s_axi4_bid), 32'h7);
      m_axi4_bvalid = 1'b0;
      m_axi4_bid    = '0;
      axi4_arst = 1'b0;
      tick();

      // single drop response
      trans_drop = 1'b1; trans_id = 10'h005; s_axi4_bready = 1'b1;
      #2; chk("d1_no_elig", 32'(s_axi4_bvalid), 0);
      tick();
      trans_drop = 1'b0; wbeat(1'b1);
      #2; chk("d1_pend1", 32'(drop_pending), 1);
      chk("d1_wait", 32'(s_axi4_bvalid), 0);
      tick();
      wbeat(1'b0);
      #2;
      chk("d1_bvalid", 32'(s_axi4_bvalid), 1);
      chk("d1_bid", 32'(s_axi4_bid), 32'h5);
      chk("d1_bresp", 32'(s_axi4_bresp), 2);
      chk("d1_buser", 32'(s_axi4_buser), 0);
      chk("d1_mready", 32'(m_axi4_bready), 0);
      chk("d1_pend_pre", 32'(drop_pending), 1);
      tick();
      #2;
      chk("d1_pend_post", 32'(drop_pending), 0);
      chk("d1_bvalid_off", 32'(s_axi4_bvalid), 0);

      // alternating drop/master arbitration
      apply_reset();
      trans_drop = 1'b1; trans_id = 10'h011; wbeat(1'b1);
      tick();
      trans_id = 10'h012;
      #2; chk("alt_setup_bid", 32'(s_axi4_bid), 32'h11);
      chk("alt_setup_bvalid", 32'(s_axi4_bvalid), 1);
      tick();
      trans_id = 10'h013; s_axi4_bready = 1'b1;
      m_axi4_bvalid = 1'b1; m_axi4_bid = 10'h003; m_axi4_bresp = 2'b00; m_axi4_buser = 4'h5;
      #2; chk("alt1_drop_bid", 32'(s_axi4_bid), 32'h11);
      chk("alt1_mready", 32'(m_axi4_bready), 0);
      tick();
      trans_drop = 1'b0; wbeat(1'b0);
      #2; chk("alt2_mst_bid", 32'(s_axi4_bid), 32'h3);
      chk("alt2_mready", 32'(m_axi4_bready), 1);
      chk("alt2_buser", 32'(s_axi4_buser), 32'h5);
      tick();
      #2; chk("alt3_drop_bid", 32'(s_axi4_bid), 32'h12);
      chk("alt3_bresp", 32'(s_axi4_bresp), 2);
      chk("alt3_mready", 32'(m_axi4_bready), 0);
      tick();
      #2; chk("alt4_mst_bid", 32'(s_axi4_bid), 32'h3);
      chk("alt4_mready", 32'(m_axi4_bready), 1);
      chk("alt_perr", 32'(proto_err), 0);

      // master beat locked while a drop becomes eligible
      apply_reset();
      m_axi4_bvalid = 1'b1; m_axi4_bid = 10'h003; m_axi4_bresp = 2'b01; m_axi4_buser = 4'h2;
      trans_drop = 1'b1; trans_id = 10'h021;
      #2; chk("lock1_bid", 32'(s_axi4_bid), 32'h3);
      chk("lock1_mready", 32'(m_axi4_bready), 0);
      tick();
      trans_drop = 1'b0; wbeat(1'b1);
      #2; chk("lock2_bid", 32'(s_axi4_bid), 32'h3);
      tick();
      wbeat(1'b0);
      #2; chk("lock3_bid", 32'(s_axi4_bid), 32'h3);
      chk("lock3_bresp", 32'(s_axi4_bresp), 1);
      chk("lock3_mready", 32'(m_axi4_bready), 0);
      tick();
      s_axi4_bready = 1'b1;
      #2; chk("lock4_bid", 32'(s_axi4_bid), 32'h3);
      chk("lock4_mready", 32'(m_axi4_bready), 1);
      tick();
      m_axi4_bvalid = 1'b0;
      #2; chk("lock5_drop_bid", 32'(s_axi4_bid), 32'h21);
      chk("lock5_bresp", 32'(s_axi4_bresp), 2);
      tick();
      #2; chk("lock_pend", 32'(drop_pending), 0);

      // FIFO full, ignored push, push+pop while full
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         trans_drop = 1'b1; trans_id = 10'(10'h031 + i);
         tick();
      end
      trans_drop = 1'b0;
      #2; chk("full_tdr", 32'(trans_drop_ready), 0);
      chk("full_pend", 32'(drop_pending), 4);
      trans_drop = 1'b1; trans_id = 10'h035;
      tick();
      trans_drop = 1'b0;
      #2; chk("full_ignore_pend", 32'(drop_pending), 4);
      wbeat(1'b1);
      tick();
      wbeat(1'b0); trans_drop = 1'b1; trans_id = 10'h036; s_axi4_bready = 1'b1;
      #2; chk("full_pp_bid", 32'(s_axi4_bid), 32'h31);
      tick();
      trans_drop = 1'b0; s_axi4_bready = 1'b0;
      #2; chk("full_pp_pend", 32'(drop_pending), 4);
      chk("full_pp_tdr", 32'(trans_drop_ready), 0);
      wbeat(1'b1);
      for (int i = 0; i < 4; i++) tick();
      wbeat(1'b0); s_axi4_bready = 1'b1;
      exp_ids = '{10'h032, 10'h033, 10'h034, 10'h036};
      for (int i = 0; i < 4; i++) begin
         #2; chk($sformatf("drain%0d_bid", i), 32'(s_axi4_bid), 32'(exp_ids[i]));
         tick();
      end
      #2; chk("drain_pend", 32'(drop_pending), 0);
      chk("drain_bvalid", 32'(s_axi4_bvalid), 0);
      chk("drain_perr", 32'(proto_err), 0);

      // protocol error, then reset clears everything
      apply_reset();
      wbeat(1'b1);
      tick();
      wbeat(1'b0);
      #2; chk("perr_set", 32'(proto_err), 1);
      trans_drop = 1'b1; trans_id = 10'h041;
      tick();
      trans_drop = 1'b0;
      #2; chk("perr_wl0", 32'(s_axi4_bvalid), 0);
      chk("perr_pend", 32'(drop_pending), 1);
      chk("perr_sticky", 32'(proto_err), 1);
      axi4_arst = 1'b1;
      tick();
      #2; chk("perr_rst_clr", 32'(proto_err), 0);
      chk("perr_rst_pend", 32'(drop_pending), 0);
      chk("perr_rst_tdr", 32'(trans_drop_ready), 1);
      axi4_arst = 1'b0;
      tick();

      // reset abandons a locked drop beat
      trans_drop = 1'b1; trans_id = 10'h051;
      tick();
      trans_drop = 1'b0; wbeat(1'b1);
      tick();
      wbeat(1'b0);
      #2; chk("ml_bid", 32'(s_axi4_bid), 32'h51);
      tick();
      #2; chk("ml_locked", 32'(s_axi4_bvalid), 1);
      axi4_arst = 1'b1;
      tick();
      #2; chk("ml_rst_bvalid", 32'(s_axi4_bvalid), 0);
      chk("ml_rst_pend", 32'(drop_pending), 0);
      axi4_arst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axi4_bch_drop_arb.md
AXI4_BCH_DROP_ARB -- requirements
Module: axi4_bch_drop_arb

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default 10, ID width of all B-channel and drop-ID ports.
REQ-002 SHALL have parameter C_AXI_USER_WIDTH, default 4, BUSER width.
REQ-003 SHALL have parameter C_DROP_DEPTH, default 4, drop-ID FIFO depth (power of two, >=2).
REQ-004 SHALL have parameter C_DROP_RESP, default 2'b10, BRESP returned for dropped transactions.
REQ-005 SHALL have port axi4_aclk  in  1  the only clock; all logic on rising edge.
REQ-006 SHALL have port axi4_arst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports trans_id  in  C_AXI_ID_WIDTH  ID of a dropped write; trans_drop  in  1  push valid; trans_drop_ready  out  1  FIFO not full.
REQ-008 SHALL have ports s_axi4_wvalid, s_axi4_wready, s_axi4_wlast  in  1 each  slave W handshake; w_drop  in  1  current W beat belongs to a dropped write.
REQ-009 SHALL have ports s_axi4_bid/bresp/buser/bvalid  out  ID/2/USER/1, s_axi4_bready  in  1  slave B channel.
REQ-010 SHALL have ports m_axi4_bid/bresp/buser/bvalid  in  ID/2/USER/1, m_axi4_bready  out  1  master B channel.
REQ-011 SHALL have ports drop_pending  out  $clog2(C_DROP_DEPTH)+1  FIFO occupancy; proto_err  out  1  sticky protocol error.

Function
REQ-012 SHALL push trans_id into the FIFO when trans_drop && trans_drop_ready; push while full SHALL be ignored (no overwrite).
REQ-013 SHALL keep counter wl_cnt (width as drop_pending), +1 on s_axi4_wvalid && s_axi4_wready && s_axi4_wlast && w_drop, -1 on each completed drop response; simultaneous +1/-1 leaves it unchanged.
REQ-014 SHALL treat a drop as eligible when FIFO non-empty and wl_cnt > 0.
REQ-015 SHALL set proto_err when a wl_cnt increment would make wl_cnt exceed FIFO occupancy (after same-cycle push/pop); wl_cnt SHALL then not increment.
REQ-016 SHALL implement grant FSM states IDLE, MST, DRP.
REQ-017 In IDLE the grant SHALL be decided combinationally: drop if eligible and (!m_axi4_bvalid or pref==DROP); else master if m_axi4_bvalid; else none (s_axi4_bvalid=0).
REQ-018 If the IDLE grant's beat is not accepted (s_axi4_bready=0), FSM SHALL move to MST or DRP and hold that grant until s_axi4_bready, then return to IDLE.
REQ-019 While granted (IDLE grant or locked), s_axi4_bvalid SHALL stay asserted and bid/bresp/buser SHALL stay stable until s_axi4_bready; no mid-beat source switch.
REQ-020 Drop grant SHALL drive bid=FIFO head, bresp=C_DROP_RESP, buser=0, m_axi4_bready=0.
REQ-021 Master grant SHALL pass m_axi4_bid/bresp/buser unchanged, m_axi4_bready=s_axi4_bready.
REQ-022 No grant or drop grant SHALL force m_axi4_bready=0.
REQ-023 On completed drop beat FIFO SHALL pop and pref:=MASTER; on completed master beat pref:=DROP.
REQ-024 Zero latency: an eligible drop with s_axi4_bready=1 and no contention SHALL complete in the same cycle eligibility appears.
REQ-025 FIFO full with simultaneous push and pop SHALL accept the push.

Reset
REQ-026 While axi4_arst is high at a rising edge: FIFO empty, wl_cnt=0, FSM=IDLE, pref=DROP, proto_err=0.
REQ-027 During and after reset: s_axi4_bvalid=m_axi4_bvalid (no drop eligible), trans_drop_ready=1, drop_pending=0; reset mid-lock SHALL abandon the locked beat.

Verification
REQ-028 Push ID 0x05, then W wlast beat with w_drop=1, s_axi4_bready=1 -> next cycle bvalid=1, bid=0x05, bresp=2'b10, buser=0, pop same cycle, drop_pending 1->0.
REQ-029 Drop eligible and m_axi4_bvalid (bid 0x3) simultaneously, bready=1 for 4 cycles, more drops queued -> alternating drop/master/drop/master, starting with drop.
REQ-030 Master beat presented with s_axi4_bready=0 for 3 cycles while drop becomes eligible -> bid stays 0x3, m_axi4_bready=0 until bready, drop follows after.
REQ-031 Push 4 IDs (depth 4) -> trans_drop_ready=0, 5th push ignored; pop+push same cycle -> accepted, drop_pending stays 4.
REQ-032 w_drop wlast with empty FIFO -> proto_err=1, wl_cnt stays 0; assert axi4_arst -> proto_err=0, all counters 0.
